// File: rtl/ex_ext_stage_pkg.sv
// Shared types for the EX result extension stage.
// Entries carry the already-extended result, its tag and the staller flag.
package struct_pckg;

    localparam int unsigned XLEN_MAX = 64;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        NONE = 2'b11
    } ext_size_e;

    typedef struct packed {
        logic [XLEN_MAX-1:0] data;
        logic [4:0]          rd;
        logic                staller;
    } ext_entry_t;

    function automatic logic [3:0] ptr_next(
        input logic [3:0] ptr,
        input int unsigned depth
    );
        return (ptr == 4'(depth - 1)) ? 4'd0 : ptr + 4'd1;
    endfunction

endpackage

// File: rtl/ex_ext_stage_unit.sv
// Combinational sign/zero extension of a raw EX result.
// Keep-mask form avoids zero-width replications when XLEN=32.
module ex_ext_unit
    import struct_pckg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] data_i,
    input  ext_size_e       size_i,
    input  logic            signed_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] keep;
    logic            msb;

    always_comb begin
        keep = '1;
        msb  = 1'b0;
        unique case (size_i)
            BYTE: begin
                keep = XLEN'(8'hFF);
                msb  = data_i[7];
            end
            HALF: begin
                keep = XLEN'(16'hFFFF);
                msb  = data_i[15];
            end
            WORD: begin
                keep = XLEN'(32'hFFFF_FFFF);
                msb  = data_i[31];
            end
            NONE: begin
                keep = '1;
                msb  = 1'b0;
            end
            default: begin
                keep = '1;
                msb  = 1'b0;
            end
        endcase
        data_o = (data_i & keep) | ((signed_i && msb) ? ~keep : '0);
    end

endmodule

// File: rtl/ex_ext_stage.sv
// EX extension stage: extends results at push and buffers them in a FIFO.
// Outputs are masked to zero whenever the buffer is empty.
module ex_ext_stage
    import struct_pckg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_data,
    input  logic [1:0]      i_size,
    input  logic            i_signed,
    input  logic [4:0]      i_rd,
    input  logic            i_is_staller,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_data,
    output logic [4:0]      o_rd,
    output logic            o_staller,
    output logic [3:0]      o_count
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [3:0]      wr_ptr_q;
    logic [3:0]      wr_ptr_d;
    logic [3:0]      rd_ptr_q;
    logic [3:0]      rd_ptr_d;
    logic [3:0]      count_q;
    logic [3:0]      count_d;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] ext_data;
    ext_entry_t      wr_entry;
    ext_entry_t      head;
    ext_entry_t      mem_q [DEPTH];

    ex_ext_unit #(
        .XLEN (XLEN)
    ) u_ext (
        .data_i   (i_data),
        .size_i   (ext_size_e'(i_size)),
        .signed_i (i_signed),
        .data_o   (ext_data)
    );

    assign o_ready = (count_q < DEPTH_C);
    assign o_valid = (count_q != 4'd0);
    assign o_count = count_q;

    // Flush wins over any handshake in the same cycle.
    assign push = i_valid && o_ready && !i_flush;
    assign pop  = o_valid && i_ready && !i_flush;

    always_comb begin
        wr_entry         = '0;
        wr_entry.data    = XLEN_MAX'(ext_data);
        wr_entry.rd      = i_rd;
        wr_entry.staller = i_is_staller;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = 4'd0;
            rd_ptr_d = 4'd0;
            count_d  = 4'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_next(wr_ptr_q, DEPTH);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q, DEPTH);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 4'd0;
            rd_ptr_q <= 4'd0;
            count_q  <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[$clog2(DEPTH)-1:0]] <= wr_entry;
        end
    end

    assign head = mem_q[rd_ptr_q[$clog2(DEPTH)-1:0]];

    always_comb begin
        o_data    = '0;
        o_rd      = 5'd0;
        o_staller = 1'b0;
        if (o_valid) begin
            o_data    = head.data[XLEN-1:0];
            o_rd      = head.rd;
            o_staller = head.staller;
        end
    end

endmodule

// File: tb/tb_ex_ext_stage.sv
// Bench for ex_ext_stage: DEPTH=2 and DEPTH=3 instances share stimulus
// and are compared against queue-based reference models.
module tb_ex_ext_stage;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        st;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic [63:0] i_data = '0;
    logic [1:0]  i_size = 2'b00;
    logic        i_signed = 1'b0;
    logic [4:0]  i_rd = '0;
    logic        i_is_staller = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_ready = 1'b0;

    logic        o_ready2, o_valid2, o_staller2;
    logic [63:0] o_data2;
    logic [4:0]  o_rd2;
    logic [3:0]  o_count2;
    logic        o_ready3, o_valid3, o_staller3;
    logic [63:0] o_data3;
    logic [4:0]  o_rd3;
    logic [3:0]  o_count3;

    ent_t q2[$];
    ent_t q3[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_ext_stage #(.XLEN(64), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready2),
        .i_data(i_data), .i_size(i_size), .i_signed(i_signed), .i_rd(i_rd),
        .i_is_staller(i_is_staller), .i_flush(i_flush), .o_valid(o_valid2),
        .i_ready(i_ready), .o_data(o_data2), .o_rd(o_rd2),
        .o_staller(o_staller2), .o_count(o_count2)
    );

    ex_ext_stage #(.XLEN(64), .DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready3),
        .i_data(i_data), .i_size(i_size), .i_signed(i_signed), .i_rd(i_rd),
        .i_is_staller(i_is_staller), .i_flush(i_flush), .o_valid(o_valid3),
        .i_ready(i_ready), .o_data(o_data3), .o_rd(o_rd3),
        .o_staller(o_staller3), .o_count(o_count3)
    );

    // Keep the low n bits, then shift back out to extend.
    function automatic logic [63:0] ref_ext(logic [63:0] d, logic [1:0] sz, logic sg);
        int n;
        logic [63:0] t;
        if (sz == 2'b11) return d;
        n = 8 << sz;
        t = d << (64 - n);
        if (sg) return 64'($signed(t) >>> (64 - n));
        return t >> (64 - n);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t h2;
        ent_t h3;
        h2 = '{64'd0, 5'd0, 1'b0};
        h3 = '{64'd0, 5'd0, 1'b0};
        if (q2.size() > 0) h2 = q2[0];
        if (q3.size() > 0) h3 = q3[0];
        chk("d2_valid", 64'(o_valid2), 64'(q2.size() != 0));
        chk("d2_ready", 64'(o_ready2), 64'(q2.size() < 2));
        chk("d2_count", 64'(o_count2), 64'(q2.size()));
        chk("d2_data", o_data2, h2.data);
        chk("d2_rd", 64'(o_rd2), 64'(h2.rd));
        chk("d2_staller", 64'(o_staller2), 64'(h2.st));
        chk("d3_valid", 64'(o_valid3), 64'(q3.size() != 0));
        chk("d3_ready", 64'(o_ready3), 64'(q3.size() < 3));
        chk("d3_count", 64'(o_count3), 64'(q3.size()));
        chk("d3_data", o_data3, h3.data);
        chk("d3_rd", 64'(o_rd3), 64'(h3.rd));
        chk("d3_staller", 64'(o_staller3), 64'(h3.st));
    endtask

    task automatic model_edge();
        bit   pu;
        bit   po;
        ent_t e;
        if (!rst_n || i_flush) begin
            q2.delete();
            q3.delete();
            return;
        end
        e = '{ref_ext(i_data, i_size, i_signed), i_rd, i_is_staller};
        pu = i_valid && (q2.size() < 2);
        po = (q2.size() > 0) && i_ready;
        if (po) void'(q2.pop_front());
        if (pu) q2.push_back(e);
        pu = i_valid && (q3.size() < 3);
        po = (q3.size() > 0) && i_ready;
        if (po) void'(q3.pop_front());
        if (pu) q3.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #3 check_all();
        chk("rst_ready", 64'(o_ready2), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Extension directed cases, one-cycle latency.
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data = 64'hDEAD_BEEF_0000_0080; i_size = 2'b00; i_signed = 1'b1; i_rd = 5'd1;
        step();
        chk("byte_sx", o_data2, 64'hFFFF_FFFF_FFFF_FF80);
        i_signed = 1'b0; i_rd = 5'd2;
        step();
        chk("byte_zx", o_data2, 64'h80);
        i_data = 64'h1234_5678_8000_1234; i_size = 2'b10; i_signed = 1'b1; i_rd = 5'd3;
        step();
        chk("word_sx", o_data2, 64'hFFFF_FFFF_8000_1234);
        i_size = 2'b11; i_rd = 5'd4;
        step();
        chk("none_pass", o_data2, 64'h1234_5678_8000_1234);
        i_valid = 1'b0;
        step();

        // Fill with downstream stalled, then pop+push at full.
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_data = {$urandom, $urandom}; i_size = 2'(k); i_rd = 5'(10 + k);
            step();
        end
        chk("full_count", 64'(o_count2), 64'd2);
        chk("full_ready", 64'(o_ready2), 64'd0);
        i_ready = 1'b1; i_rd = 5'd13;
        step();
        chk("full_nopush", 64'(o_count2), 64'd1);
        chk("full_head", 64'(o_rd2), 64'd11);
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // Random traffic with toggling downstream readiness.
        for (int c = 0; c < 60; c++) begin
            i_valid = ($urandom % 4) != 0;
            i_ready = (c % 2 == 0) ? 1'b1 : 1'($urandom % 2);
            i_data = {$urandom, $urandom};
            i_size = 2'($urandom);
            i_signed = 1'($urandom);
            i_rd = 5'(c);
            i_is_staller = 1'($urandom);
            step();
        end
        i_valid = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Flush a full buffer of staller entries.
        i_ready = 1'b0; i_valid = 1'b1; i_is_staller = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_rd = 5'(20 + k); i_data = {$urandom, $urandom};
            step();
        end
        chk("stall_vis", 64'(o_staller2), 64'd1);
        i_flush = 1'b1; i_ready = 1'b1;
        step();
        chk("flush_valid", 64'(o_valid2), 64'd0);
        chk("flush_stall", 64'(o_staller2), 64'd0);
        chk("flush_count", 64'(o_count3), 64'd0);
        i_flush = 1'b0; i_valid = 1'b0; i_is_staller = 1'b0;
        step();

        // Asynchronous reset with two entries buffered.
        i_ready = 1'b0; i_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_rd = 5'(25 + k); i_data = {$urandom, $urandom};
            step();
        end
        i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 q2.delete();
        q3.delete();
        check_all();
        chk("rst_async_data", o_data3, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        i_valid = 1'b1; i_rd = 5'd5; i_data = 64'h55; i_size = 2'b11;
        step();
        chk("post_rst_valid", 64'(o_valid2), 64'd1);
        chk("post_rst_rd", 64'(o_rd2), 64'd5);
        i_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_ext_stage.md
EX_EXT_STAGE -- requirements
Module: ex_ext_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 2, output buffer entries; legal values 2 to 8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_valid  input  1  upstream entry valid.
REQ-006 o_ready  output  1  stage can accept an entry this cycle.
REQ-007 i_data  input  XLEN  raw EX result.
REQ-008 i_size  input  2  00 byte, 01 half, 10 word, 11 none.
REQ-009 i_signed  input  1  1 selects sign extension, 0 selects zero extension.
REQ-010 i_rd  input  5  destination register tag, carried unchanged.
REQ-011 i_is_staller  input  1  entry originates from a stalling instruction.
REQ-012 i_flush  input  1  discard all buffered entries.
REQ-013 o_valid  output  1  head entry valid.
REQ-014 i_ready  input  1  downstream accepts the head entry.
REQ-015 o_data  output  XLEN  extended head result.
REQ-016 o_rd  output  5  head tag.
REQ-017 o_staller  output  1  head staller flag, gated by o_valid.
REQ-018 o_count  output  4  number of occupied entries.

Function
REQ-019 Push when i_valid && o_ready; pop when o_valid && i_ready.
REQ-020 Extension is applied at push and stores the extended value, so extension adds no logic to the output path.
REQ-021 Extension rule: size 00/01/10 takes bits [7:0]/[15:0]/[31:0], sign- or zero-extended to XLEN per i_signed.
REQ-022 Size 11 passes i_data unchanged; when XLEN=32, size 10 also passes i_data unchanged.
REQ-023 Latency: an entry pushed in cycle N appears on o_valid in cycle N+1.
REQ-024 Entries leave in push order (FIFO).
REQ-025 o_ready = (count < DEPTH), from registered state only; at full, a simultaneous pop does not enable a push that cycle.
REQ-026 Simultaneous push and pop when not full leaves count unchanged.
REQ-027 Read and write pointers wrap modulo DEPTH, including non-power-of-two DEPTH.
REQ-028 When empty, o_valid=0, o_staller=0, o_data=0, o_rd=0.
REQ-029 o_staller=0 whenever o_valid=0; a stored staller bit is never visible on an invalid entry.
REQ-030 i_flush: count and both pointers clear at the next edge; a push or pop in the same cycle is ignored; o_valid=0 in the following cycle.
REQ-031 i_data, i_size and i_signed are ignored when i_valid=0.

Reset
REQ-032 Asserting rst_n=0 immediately sets count=0, pointers=0, o_valid=0, o_staller=0, o_data=0, o_rd=0, o_count=0, o_ready=1.
REQ-033 Reset mid-operation discards all entries; the first push after deassertion behaves as a push into an empty buffer.
REQ-034 Buffer storage needs no reset; outputs are masked while count=0.

Structure
REQ-035 Package struct_pckg holds enum ext_size_e (BYTE, HALF, WORD, NONE) and struct ext_entry_t (data, rd, staller).
REQ-036 Extension is the combinational sub-module ex_ext_unit (parameter XLEN; inputs data/size/signed; output extended data); ex_ext_stage owns the FIFO.

Verification
REQ-037 XLEN=64: push 0x...0080, size 00, signed=1 -> o_data=0xFFFF_FFFF_FFFF_FF80 one cycle later; the same input with signed=0 -> 0x80.
REQ-038 XLEN=64: push 0x1234_5678_8000_1234, size 10, signed=1 -> 0xFFFF_FFFF_8000_1234; size 11 -> the input unchanged.
REQ-039 DEPTH=2, i_ready=0, three push attempts -> two accepted, o_ready=0, o_count=2; hold i_ready=1 and the entries drain in order, and pop plus push at full is refused.
REQ-040 DEPTH=3, 10 back-to-back push/pop with i_ready toggling -> all rd tags emerge in order, pointer wrap covered, no loss or duplication.
REQ-041 Push with i_is_staller=1, then assert i_flush with the buffer full -> next cycle o_valid=0, o_staller=0, o_count=0.
REQ-042 Drop rst_n with 2 entries buffered -> outputs zero immediately, before the next clk edge; after release, the first push appears after 1 cycle.
